// File: rtl/sensor_pkg.sv
// Shared constants, state encoding and sensor indices for the sensor polling controller.
// The SENSOR_TIMEOUT_EN build also uses TIMEOUT_CYC from this package.
package sensor_pkg;

  localparam int DATA_W      = 8;
  localparam int SUM_W       = DATA_W + 2;
  localparam int TIMEOUT_CYC = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POLL = 2'd1,
    CALC = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic [1:0] SENS_1 = 2'd0;
  localparam logic [1:0] SENS_2 = 2'd1;
  localparam logic [1:0] SENS_3 = 2'd2;
  localparam logic [1:0] SENS_4 = 2'd3;

endpackage

// File: rtl/height_calc.sv
// Combinational height fusion: a rounded average of all four samples, or a rounded
// average of one opposing pair when a zero sample marks a reading as missing.
module height_calc
  import sensor_pkg::*;
(
  input  logic [DATA_W-1:0] s1,
  input  logic [DATA_W-1:0] s2,
  input  logic [DATA_W-1:0] s3,
  input  logic [DATA_W-1:0] s4,
  output logic [DATA_W-1:0] height
);

  logic [SUM_W-1:0] sum_all;
  logic [SUM_W-1:0] sum_13;
  logic [SUM_W-1:0] sum_24;

  always_comb begin
    sum_all = SUM_W'(s1) + SUM_W'(s2) + SUM_W'(s3) + SUM_W'(s4) + SUM_W'(2);
    sum_13  = SUM_W'(s1) + SUM_W'(s3) + SUM_W'(1);
    sum_24  = SUM_W'(s2) + SUM_W'(s4) + SUM_W'(1);
    height  = '0;
    if (s1 != '0 && s2 != '0 && s3 != '0 && s4 != '0)
      height = DATA_W'(sum_all >> 2);
    // the s1/s3 pair takes priority when both pairs hold a zero
    else if (s2 == '0 || s4 == '0)
      height = DATA_W'(sum_13 >> 1);
    else
      height = DATA_W'(sum_24 >> 1);
  end

endmodule

// File: rtl/sensor_poll_ctrl.sv
// Polls four height sensors over one req/ack port, fuses the samples and offers the
// result on a valid/ready port. Define SENSOR_TIMEOUT_EN to time out silent sensors.
module sensor_poll_ctrl
  import sensor_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic [1:0]        sens_sel,
  output logic              sens_req,
  input  logic              sens_ack,
  input  logic [DATA_W-1:0] sens_data,
  output logic [DATA_W-1:0] height,
  output logic              height_valid,
  input  logic              height_ready,
  output logic [3:0]        fault_mask
);

  // Handshakes: a sensor read completes in any cycle where sens_req and sens_ack are
  // both high; a result transfers in any cycle where height_valid and height_ready are.
  state_t            state, state_nx;
  logic [1:0]        idx, idx_nx;
  logic [DATA_W-1:0] samples [4];
  logic [DATA_W-1:0] fused;
  logic              ack_ok;
  logic              tmo;
  logic              adv;

  assign ack_ok = sens_req & sens_ack;
  assign adv    = ack_ok | tmo;

`ifdef SENSOR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;

  // the ack wins when it lands in the same cycle as the timeout
  assign tmo = sens_req & ~sens_ack & (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (state != POLL || adv)
      cnt <= '0;
    else
      cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fault_mask <= '0;
    else if (state == IDLE && start)
      fault_mask <= '0;
    else if (tmo)
      fault_mask[idx] <= 1'b1;
  end
`else
  assign tmo        = 1'b0;
  assign fault_mask = '0;
`endif

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE: if (start) begin
        state_nx = POLL;
        idx_nx   = SENS_1;
      end
      POLL: if (adv) begin
        // idx wraps back to SENS_1 as the last sensor completes
        idx_nx = idx + 2'd1;
        if (idx == SENS_4) state_nx = CALC;
      end
      CALC:    state_nx = OUT;
      OUT:     if (height_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= SENS_1;
      sens_sel     <= SENS_1;
      sens_req     <= 1'b0;
      busy         <= 1'b0;
      height_valid <= 1'b0;
    end else begin
      state        <= state_nx;
      idx          <= idx_nx;
      sens_sel     <= idx_nx;
      sens_req     <= (state_nx == POLL);
      busy         <= (state_nx != IDLE);
      height_valid <= (state_nx == OUT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) samples[i] <= '0;
    end else if (adv) begin
      samples[idx] <= ack_ok ? sens_data : '0;
    end
  end

  height_calc u_height_calc (
    .s1     (samples[0]),
    .s2     (samples[1]),
    .s3     (samples[2]),
    .s4     (samples[3]),
    .height (fused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      height <= '0;
    else if (state == CALC)
      height <= fused;
  end

endmodule

// File: tb/tb_sensor_poll_ctrl.sv
// Bench for sensor_poll_ctrl: spec vectors, hand-written corner sequences and random
// rounds checked against an arithmetic fusion model and an expected-height queue.
module tb_sensor_poll_ctrl;

  localparam int TO_CYC = 15;
  localparam int BUDGET = 400;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic [1:0] sens_sel;
  logic       sens_req;
  logic       sens_ack;
  logic [7:0] sens_data;
  logic [7:0] height;
  logic       height_valid;
  logic       height_ready;
  logic [3:0] fault_mask;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [3:0][7:0] s;
    logic [7:0]      exp_h;
  } vec_t;

  vec_t tv[7];

  sensor_poll_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .sens_sel     (sens_sel),
    .sens_req     (sens_req),
    .sens_ack     (sens_ack),
    .sens_data    (sens_data),
    .height       (height),
    .height_valid (height_valid),
    .height_ready (height_ready),
    .fault_mask   (fault_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference fusion from the averaging rule, in plain integer arithmetic.
  function automatic int fuse(input logic [3:0][7:0] s);
    int a, b, c, d;
    a = s[0]; b = s[1]; c = s[2]; d = s[3];
    if (a != 0 && b != 0 && c != 0 && d != 0) return (a + b + c + d + 2) / 4;
    if (b == 0 || d == 0) return (a + c + 1) / 2;
    return (b + d + 1) / 2;
  endfunction

  function automatic logic [3:0][7:0] mk(input int a, input int b, input int c, input int d);
    logic [3:0][7:0] r;
    r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c); r[3] = 8'(d);
    return r;
  endfunction

  // One poll round from IDLE. dly[i] = cycles before sensor i acks; never_idx names a
  // sensor that never acks (-1 for none). Called and returns on a negedge.
  task automatic run_round(input logic [3:0][7:0] smp, input logic [3:0][7:0] dly,
                           input int rdy_dly, input int never_idx, input bit pulse_start,
                           output int lat);
    int idx, wait_c, cyc, ready_c;
    bit calc_seen, ack_now, done;
    logic [3:0][7:0] eff;
    logic [7:0] exp_h;
    logic [3:0] exp_mask;
    eff = smp;
    exp_mask = 4'b0000;
    if (never_idx >= 0) begin
      eff[never_idx] = 8'd0;
      exp_mask[never_idx] = 1'b1;
    end
    exp_q.push_back(8'(fuse(eff)));
    idx = 0; wait_c = 0; ready_c = 0; calc_seen = 0; done = 0; lat = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (cyc = 1; cyc < BUDGET && !done; cyc++) begin
      sens_ack = 1'b0;
      sens_data = 8'($urandom);
      height_ready = 1'b0;
      start = 1'b0;
      if (idx < 4) begin
        chk("poll_req", {31'd0, sens_req}, 1);
        chk("poll_sel", {30'd0, sens_sel}, idx);
        chk("poll_busy", {31'd0, busy}, 1);
        ack_now = (idx != never_idx) && (wait_c >= int'(dly[idx]));
        if (ack_now) begin
          sens_ack = 1'b1;
          sens_data = smp[idx];
        end
        if (ack_now || (idx == never_idx && wait_c == TO_CYC - 1)) begin
          idx++;
          wait_c = 0;
        end else begin
          wait_c++;
        end
      end else if (!calc_seen) begin
        chk("calc_req", {31'd0, sens_req}, 0);
        chk("calc_valid", {31'd0, height_valid}, 0);
        calc_seen = 1;
      end else begin
        chk("out_valid", {31'd0, height_valid}, 1);
        if (lat < 0) begin
          lat = cyc;
          exp_h = exp_q.pop_front();
          if (pulse_start) start = 1'b1;
        end
        chk("out_height", {24'd0, height}, {24'd0, exp_h});
        if (ready_c >= rdy_dly) begin
          height_ready = 1'b1;
          @(negedge clk);
          height_ready = 1'b0;
          chk("hs_valid_drop", {31'd0, height_valid}, 0);
          chk("hs_busy_drop", {31'd0, busy}, 0);
          chk("hs_height_hold", {24'd0, height}, {24'd0, exp_h});
          chk("fault_mask", {28'd0, fault_mask}, {28'd0, exp_mask});
          done = 1;
        end
        ready_c++;
      end
      if (!done) @(negedge clk);
    end
    sens_ack = 1'b0;
    if (!done) begin
      chk("round_budget", 0, 1);
      exp_q.delete();
    end
  endtask

  initial begin
    logic [3:0][7:0] smp, dly;
    int lat;
    tv[0] = '{s: mk(10, 20, 30, 40),  exp_h: 8'd25};
    tv[1] = '{s: mk(10, 0, 30, 41),   exp_h: 8'd20};
    tv[2] = '{s: mk(0, 7, 50, 8),     exp_h: 8'd8};
    tv[3] = '{s: mk(0, 0, 5, 6),      exp_h: 8'd3};
    tv[4] = '{s: mk(255, 255, 255, 255), exp_h: 8'd255};
    tv[5] = '{s: mk(1, 1, 1, 2),      exp_h: 8'd1};
    tv[6] = '{s: mk(1, 1, 2, 2),      exp_h: 8'd2};

    rst_n = 1'b0; start = 1'b0; sens_ack = 1'b0; sens_data = '0; height_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_req", {31'd0, sens_req}, 0);
    chk("rst_sel", {30'd0, sens_sel}, 0);
    chk("rst_height", {24'd0, height}, 0);
    chk("rst_valid", {31'd0, height_valid}, 0);
    chk("rst_fault", {28'd0, fault_mask}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Stray acks outside POLL must not start anything.
    for (int i = 0; i < 3; i++) begin
      sens_ack = 1'b1; sens_data = 8'($urandom);
      @(negedge clk);
      chk("idle_ack_ignored", {31'd0, busy}, 0);
    end
    sens_ack = 1'b0;

    // Spec vectors with immediate acks and immediate ready.
    for (int v = 0; v < 7; v++) begin
      chk("vec_model", fuse(tv[v].s), {24'd0, tv[v].exp_h});
      run_round(tv[v].s, '0, 0, -1, 1'b0, lat);
      chk("vec_latency", lat, 6);
    end

    // Consumer stalls 5 cycles while start pulses in OUT: exactly one result.
    run_round(mk(10, 20, 30, 40), '0, 5, -1, 1'b1, lat);
    for (int i = 0; i < 3; i++) begin
      chk("start_ignored_busy", {31'd0, busy}, 0);
      chk("start_ignored_valid", {31'd0, height_valid}, 0);
      @(negedge clk);
    end

    // Ack delay stretches latency one cycle per delayed cycle.
    run_round(mk(10, 20, 30, 40), mk(1, 0, 2, 0), 0, -1, 1'b0, lat);
    chk("delay_latency", lat, 9);

    // Reset mid-round at sensor index 2.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sens_ack = 1'b1; sens_data = 8'd99;
    @(negedge clk);
    sens_data = 8'd98;
    @(negedge clk);
    sens_ack = 1'b0;
    chk("pre_rst_sel", {30'd0, sens_sel}, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, sens_req}, 0);
    chk("async_rst_busy", {31'd0, busy}, 0);
    chk("async_rst_sel", {30'd0, sens_sel}, 0);
    chk("async_rst_height", {24'd0, height}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_round(mk(4, 0, 8, 200), '0, 0, -1, 1'b0, lat);

`ifdef SENSOR_TIMEOUT_EN
    run_round(mk(10, 77, 30, 40), '0, 0, 1, 1'b0, lat);
    chk("timeout_latency", lat, 6 + TO_CYC - 1);
`endif

    // Random rounds; zeros are biased in to exercise the pair rules.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 4; i++) begin
        smp[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        dly[i] = 8'($urandom_range(0, 3));
      end
      run_round(smp, dly, $urandom_range(0, 3), -1, 1'b0, lat);
      chk("rand_latency", lat, 6 + int'(dly[0]) + int'(dly[1]) + int'(dly[2]) + int'(dly[3]));
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
